// File: rtl/game_pkg.sv
// Map geometry shared by the game-calc blocks, plus the tag that rides alongside each collision RAM read.
package game_pkg;

  localparam int MAP_W   = 960;
  localparam int MAP_H   = 500;
  localparam int MAP_AW  = 20;
  localparam int COORD_W = 10;
  localparam int IDX_W   = 3;

  typedef struct packed {
    logic             valid;
    logic             oob;
    logic [IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/collision_lookup_arbiter_if.sv
// Requester-side lookup bus and collision RAM port of the lookup arbiter.
interface collision_lookup_arbiter_if
  import game_pkg::*;
#(
  parameter int NREQ = 4
);

  logic [NREQ-1:0]         req;
  logic [NREQ*COORD_W-1:0] x_flat;
  logic [NREQ*COORD_W-1:0] y_flat;
  logic [NREQ-1:0]         ack;
  logic [NREQ-1:0]         blk;
  logic                    ram_en;
  logic [MAP_AW-1:0]       ram_addr;
  logic                    ram_dout;

  modport master (
    output req, x_flat, y_flat, ram_dout,
    input  ack, blk, ram_en, ram_addr
  );

  modport slave (
    input  req, x_flat, y_flat, ram_dout,
    output ack, blk, ram_en, ram_addr
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] elig_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   ptr_nxt_o
);

  logic [PW-1:0] idx;

  // Scan from the farthest offset down so the closest eligible index wins.
  always_comb begin
    gnt_o     = '0;
    ptr_nxt_o = ptr_i;
    idx       = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      idx = PW'((int'(ptr_i) + off) % NREQ);
      if (elig_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
        ptr_nxt_o  = PW'((int'(idx) + 1) % NREQ);
      end
    end
  end

endmodule

// File: rtl/collision_lookup_arbiter.sv
// Round-robin sharing of the collision-map RAM; ack/blk return RD_LAT+1 cycles after grant.
// COLL_OOB_CHECK_EN: off-map lookups skip the RAM read and report blk=1.
module collision_lookup_arbiter #(
  parameter int NREQ   = 4,
  parameter int MAP_W  = game_pkg::MAP_W,
  parameter int MAP_H  = game_pkg::MAP_H,
  parameter int RD_LAT = 1
) (
  input logic                        sys_clk,
  input logic                        RST,
  collision_lookup_arbiter_if.slave  bus
);

  import game_pkg::*;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    elig, gnt;
  logic [NREQ-1:0]    inflight_q, inflight_d;
  logic [NREQ-1:0]    ack_q, ack_d, blk_q, blk_d;
  logic [PW-1:0]      ptr_q, ptr_d, exit_idx;
  logic               ram_en_q, ram_en_d;
  logic [MAP_AW-1:0]  addr_q, addr_d;
  logic [COORD_W-1:0] gx, gy;
  logic               g_any, g_oob;
  tag_t               tag_in, tag_out;
  tag_t               tag_q [RD_LAT+1];

  assign elig = bus.req & ~inflight_q;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .elig_i    (elig),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .ptr_nxt_o (ptr_d)
  );

  always_comb begin
    gx     = '0;
    gy     = '0;
    tag_in = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gx         = bus.x_flat[i*COORD_W +: COORD_W];
        gy         = bus.y_flat[i*COORD_W +: COORD_W];
        tag_in.idx = IDX_W'(i);
      end
    end
    g_any = |gnt;
`ifdef COLL_OOB_CHECK_EN
    g_oob = g_any && ((int'(gx) >= MAP_W) || (int'(gy) >= MAP_H));
`else
    g_oob = 1'b0;
`endif
    tag_in.valid = g_any;
    tag_in.oob   = g_oob;
    addr_d   = g_any ? (MAP_AW'(gx) + MAP_AW'(gy) * MAP_AW'(MAP_W)) : addr_q;
    ram_en_d = g_any & ~g_oob;
  end

  // The exiting tag is the read whose data is on ram_dout this cycle.
  assign tag_out  = tag_q[RD_LAT];
  assign exit_idx = PW'(tag_out.idx);

  always_comb begin
    ack_d      = '0;
    blk_d      = blk_q;
    inflight_d = inflight_q | gnt;
    if (tag_out.valid) begin
      ack_d[exit_idx]      = 1'b1;
      blk_d[exit_idx]      = tag_out.oob ? 1'b1 : bus.ram_dout;
      inflight_d[exit_idx] = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (RST) begin
      ptr_q      <= '0;
      inflight_q <= '0;
      ack_q      <= '0;
      blk_q      <= '0;
      ram_en_q   <= 1'b0;
      addr_q     <= '0;
      for (int s = 0; s <= RD_LAT; s++) tag_q[s] <= '0;
    end else begin
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
      ack_q      <= ack_d;
      blk_q      <= blk_d;
      ram_en_q   <= ram_en_d;
      addr_q     <= addr_d;
      tag_q[0]   <= tag_in;
      for (int s = 1; s <= RD_LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  assign bus.ack      = ack_q;
  assign bus.blk      = blk_q;
  assign bus.ram_en   = ram_en_q;
  assign bus.ram_addr = addr_q;

endmodule

// File: tb/tb_collision_lookup_arbiter.sv
// Randomised and directed checks of the collision lookup arbiter against a cycle-level reference model.
module tb_collision_lookup_arbiter;

  localparam int N = 4;

  logic sys_clk = 1'b0;
  logic RST     = 1'b1;
  always #5 sys_clk = ~sys_clk;

  collision_lookup_arbiter_if #(.NREQ(N)) bus ();

  collision_lookup_arbiter #(
    .NREQ(N), .MAP_W(960), .MAP_H(500), .RD_LAT(1)
  ) dut (
    .sys_clk (sys_clk),
    .RST     (RST),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Collision map contents: a fixed pseudo-random pattern of the flat address.
  function automatic logic map_bit(input int a);
    return a[0] ^ a[6] ^ a[13] ^ a[19];
  endfunction

  // RAM with one cycle read latency.
  always @(posedge sys_clk) bus.ram_dout <= map_bit(int'(bus.ram_addr));

  logic [N-1:0] req_v;
  int           xs [N];
  int           ys [N];

  // Reference model: pointer, who is waiting for data, when and with which bit.
  int           ptr;
  bit           busy [N];
  int           due  [N];
  bit           pblk [N];
  int           edge_no = 0;
  logic [N-1:0] exp_ack, exp_blk;
  logic         exp_en;
  logic [19:0]  exp_addr;

  task automatic model_edge();
    bit [N-1:0] elig;
    int g, c, a;
    bit oob;
    if (RST) begin
      ptr = 0;
      for (int i = 0; i < N; i++) busy[i] = 0;
      exp_ack = '0; exp_blk = '0; exp_en = 0; exp_addr = '0;
    end else begin
      for (int i = 0; i < N; i++) elig[i] = req_v[i] && !busy[i];
      exp_ack = '0;
      for (int i = 0; i < N; i++) begin
        if (busy[i] && due[i] == edge_no) begin
          exp_ack[i] = 1'b1;
          exp_blk[i] = pblk[i];
          busy[i]    = 0;
        end
      end
      g = -1;
      for (int k = 0; k < N; k++) begin
        c = (ptr + k) % N;
        if (g < 0 && elig[c]) g = c;
      end
      exp_en = 1'b0;
      if (g >= 0) begin
        a   = (xs[g] + ys[g] * 960) & 32'hFFFFF;
        oob = 0;
`ifdef COLL_OOB_CHECK_EN
        oob = (xs[g] >= 960) || (ys[g] >= 500);
`endif
        ptr      = (g + 1) % N;
        busy[g]  = 1;
        due[g]   = edge_no + 2;
        pblk[g]  = oob ? 1'b1 : map_bit(a);
        exp_en   = !oob;
        exp_addr = a[19:0];
      end
    end
    edge_no++;
  endtask

  task automatic apply();
    bus.req = req_v;
    for (int i = 0; i < N; i++) begin
      bus.x_flat[i*10 +: 10] = 10'(xs[i]);
      bus.y_flat[i*10 +: 10] = 10'(ys[i]);
    end
  endtask

  task automatic tick();
    apply();
    model_edge();
    @(posedge sys_clk);
    #1;
    check_eq("ack", 32'(bus.ack), 32'(exp_ack));
    check_eq("blk", 32'(bus.blk), 32'(exp_blk));
    check_eq("ram_en", 32'(bus.ram_en), 32'(exp_en));
    if (exp_en) check_eq("ram_addr", 32'(bus.ram_addr), 32'(exp_addr));
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  initial begin
    int prev;
    logic [3:0] oh;
    req_v = '0;
    for (int i = 0; i < N; i++) begin xs[i] = 0; ys[i] = 0; end

    tick();
    tick();
    check_eq("rst_addr", 32'(bus.ram_addr), 32'd0);
    RST = 1'b0;

    // Single requester, known address and two-cycle latency.
    xs[0] = 220; ys[0] = 360; req_v = 4'b0001;
    tick();
    check_eq("t1_addr", 32'(bus.ram_addr), 32'd345820);
    check_eq("t1_en", 32'(bus.ram_en), 32'd1);
    tick();
    check_eq("t1_noack", 32'(bus.ack), 32'd0);
    tick();
    check_eq("t1_ack", 32'(bus.ack), 32'b0001);
    check_eq("t1_blk", 32'(bus.blk[0]), 32'(map_bit(345820)));
    req_v = '0;
    repeat (3) tick();

    // All four held from reset: strict 0,1,2,3 rotation of grants and acks.
    do_reset();
    for (int i = 0; i < N; i++) begin xs[i] = 100 * i + 3; ys[i] = 10 * i + 1; end
    req_v = 4'b1111;
    for (int j = 0; j < 16; j++) begin
      tick();
      check_eq("t2_gnt", 32'(bus.ram_addr), 32'(xs[j % 4] + ys[j % 4] * 960));
      if (j >= 2) begin
        oh = 4'b0001 << ((j - 2) % 4);
        check_eq("t2_order", 32'(bus.ack), 32'(oh));
      end
    end
    req_v = '0;
    repeat (4) tick();

    // Requester 2 keeps req high through its ack: reissue every third cycle.
    do_reset();
    xs[2] = 500; ys[2] = 499; req_v = 4'b0100;
    prev = -1;
    for (int j = 0; j < 12; j++) begin
      tick();
      if (bus.ram_en === 1'b1) begin
        if (prev >= 0) check_eq("t3_interval", 32'(j - prev), 32'd3);
        prev = j;
      end
    end
    req_v = '0;
    repeat (4) tick();

`ifdef COLL_OOB_CHECK_EN
    do_reset();
    xs[1] = 960; ys[1] = 0; req_v = 4'b0010;
    tick();
    check_eq("t4_oob_en", 32'(bus.ram_en), 32'd0);
    tick();
    tick();
    check_eq("t4_oob_ack", 32'(bus.ack), 32'b0010);
    check_eq("t4_oob_blk", 32'(bus.blk[1]), 32'd1);
`else
    do_reset();
    xs[1] = 959; ys[1] = 499; req_v = 4'b0010;
    tick();
    check_eq("t4_corner_addr", 32'(bus.ram_addr), 32'd479999);
    tick();
    tick();
    check_eq("t4_corner_ack", 32'(bus.ack), 32'b0010);
`endif
    req_v = '0;
    repeat (3) tick();

    // Reset while requesters 0 and 1 are in flight.
    do_reset();
    for (int i = 0; i < N; i++) begin xs[i] = 37 * i + 5; ys[i] = 11 * i + 2; end
    req_v = 4'b0011;
    tick();
    tick();
    RST = 1'b1;
    tick();
    check_eq("t5_rst_ack", 32'(bus.ack), 32'd0);
    check_eq("t5_rst_en", 32'(bus.ram_en), 32'd0);
    check_eq("t5_rst_addr", 32'(bus.ram_addr), 32'd0);
    check_eq("t5_rst_blk", 32'(bus.blk), 32'd0);
    RST = 1'b0;
    req_v = '0;
    for (int j = 0; j < 5; j++) begin
      tick();
      check_eq("t5_noack", 32'(bus.ack), 32'd0);
    end
    req_v = 4'b1111;
    tick();
    check_eq("t5_ptr0", 32'(bus.ram_addr), 32'(xs[0] + ys[0] * 960));
    req_v = '0;
    repeat (4) tick();

    // Random traffic: hold until ack, sometimes keep going, sometimes drop early.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req_v[i]) begin
          if (exp_ack[i] && $urandom_range(1, 0) == 1) req_v[i] = 1'b0;
          else if ($urandom_range(29, 0) == 0) req_v[i] = 1'b0;
        end else if ($urandom_range(2, 0) == 0) begin
          req_v[i] = 1'b1;
          xs[i]    = $urandom_range(1023, 0);
          ys[i]    = $urandom_range(1023, 0);
        end
      end
      tick();
    end
    req_v = '0;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
